// File: rtl/press_pkg.sv
// Shared types and default timing constants for the button press classifier.
package press_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD1 = 2'd1,
    WAIT2 = 2'd2,
    LOCK  = 2'd3
  } press_state_t;

  localparam int unsigned PRESS_WINDOW_DEF = 25_000_000;
  localparam int unsigned PRESS_LONG_DEF   = 100_000_000;
  localparam int unsigned PRESS_CNT_W_DEF  = 27;

endpackage

// File: rtl/press_classifier.sv
// Classifies a button gesture as single, double or long press and emits one
// registered one-cycle pulse per gesture.
module press_classifier
  import press_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = PRESS_WINDOW_DEF,
  parameter int unsigned LONG_CYCLES   = PRESS_LONG_DEF,
  parameter int unsigned CNT_W         = PRESS_CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic press_pulse,
  input  logic btn_level,
  output logic single_o,
  output logic double_o,
  output logic long_o,
  output logic busy_o
);

  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  press_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             single_d, double_d, long_d, busy_d;

  // State, counter and registered event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      single_o <= 1'b0;
      double_o <= 1'b0;
      long_o   <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_o <= single_d;
      double_o <= double_d;
      long_o   <= long_d;
      busy_o   <= busy_d;
    end
  end

  // Next state; terminal compares stop the counter, so it never wraps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (press_pulse) state_d = HELD1;
      end
      HELD1: begin
        // Release wins over the long-press terminal count.
        if (!btn_level) begin
          state_d = WAIT2;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LOCK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT2: begin
        // A press in the timeout cycle still counts as a double.
        if (press_pulse) begin
          double_d = 1'b1;
          state_d  = LOCK;
        end else if (cnt_q == WIN_LAST) begin
          single_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LOCK: begin
        if (!btn_level) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_press_classifier.sv
// Self-checking bench for press_classifier with WINDOW_CYCLES=8, LONG_CYCLES=16.
module tb_press_classifier;

  localparam int unsigned W_CYC = 8;
  localparam int unsigned L_CYC = 16;

  localparam logic [2:0] EV_N = 3'b000;
  localparam logic [2:0] EV_S = 3'b100;
  localparam logic [2:0] EV_D = 3'b010;
  localparam logic [2:0] EV_L = 3'b001;

  typedef struct {
    int         h1;
    int         gap;
    int         h2;
    logic [2:0] ev1;
    int         off1;
    logic [2:0] ev2;
    int         off2;
  } vec_t;

  typedef struct {
    logic [2:0] ev;
    int         edge_no;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic press_pulse = 1'b0;
  logic btn_level = 1'b0;
  logic single_o, double_o, long_o, busy_o;
  logic [2:0] ev_vec;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int ev_cnt = 0;
  int pulse_cnt = 0;
  bit sb_en = 1'b1;
  sb_t sb_q[$];

  press_classifier #(
    .WINDOW_CYCLES(W_CYC),
    .LONG_CYCLES  (L_CYC),
    .CNT_W        (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .press_pulse(press_pulse),
    .btn_level  (btn_level),
    .single_o   (single_o),
    .double_o   (double_o),
    .long_o     (long_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  assign ev_vec = {single_o, double_o, long_o};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Scoreboard monitor: every event pulse is matched against the queue head.
  always @(negedge clk) begin
    if (rst_n && ev_vec != EV_N) begin
      checks++;
      if ($countones(ev_vec) != 1) begin
        errors++;
        $display("FAIL onehot: events %b at edge %0d", ev_vec, edge_cnt);
      end else if (!sb_en) begin
        ev_cnt++;
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected: event %b at edge %0d, none expected", ev_vec, edge_cnt);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (e.ev != ev_vec || e.edge_no != edge_cnt) begin
          errors++;
          $display("FAIL event: got %b at edge %0d expected %b at edge %0d",
                   ev_vec, edge_cnt, e.ev, e.edge_no);
        end
      end
    end
  end

  // Drive one cycle of inputs at the falling edge; sampled at the next rising edge.
  task automatic step(input logic p, input logic l);
    press_pulse = p;
    btn_level   = l;
    @(negedge clk);
  endtask

  task automatic push_ev(input logic [2:0] ev, input int edge_no);
    sb_t e;
    e.ev = ev;
    e.edge_no = edge_no;
    sb_q.push_back(e);
  endtask

  task automatic idle_and_check(input string name, input int n);
    repeat (n) step(1'b0, 1'b0);
    chk({name, "_drained"}, sb_q.size(), 0);
    chk({name, "_busy_idle"}, int'(busy_o), 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int p_edge;
    p_edge = edge_cnt + 1;
    if (v.ev1 != EV_N) push_ev(v.ev1, p_edge + v.off1);
    if (v.ev2 != EV_N) push_ev(v.ev2, p_edge + v.off2);
    step(1'b1, 1'b1);
    chk($sformatf("v%0d_busy_rise", idx), int'(busy_o), 1);
    repeat (v.h1 - 1) step(1'b0, 1'b1);
    if (v.gap > 0) begin
      repeat (v.gap) step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      repeat (v.h2 - 1) step(1'b0, 1'b1);
    end
    idle_and_check($sformatf("v%0d", idx), 40);
  endtask

  vec_t vecs[10];

  initial begin
    int p_edge;
    logic lvl, prev;

    vecs[0] = '{h1: 3,  gap: 0, h2: 0, ev1: EV_S, off1: 11, ev2: EV_N, off2: 0};
    vecs[1] = '{h1: 3,  gap: 4, h2: 5, ev1: EV_D, off1: 7,  ev2: EV_N, off2: 0};
    vecs[2] = '{h1: 30, gap: 0, h2: 0, ev1: EV_L, off1: 16, ev2: EV_N, off2: 0};
    vecs[3] = '{h1: 3,  gap: 8, h2: 2, ev1: EV_D, off1: 11, ev2: EV_N, off2: 0};
    vecs[4] = '{h1: 3,  gap: 9, h2: 2, ev1: EV_S, off1: 11, ev2: EV_S, off2: 22};
    vecs[5] = '{h1: 16, gap: 0, h2: 0, ev1: EV_S, off1: 24, ev2: EV_N, off2: 0};
    vecs[6] = '{h1: 17, gap: 0, h2: 0, ev1: EV_L, off1: 16, ev2: EV_N, off2: 0};
    vecs[7] = '{h1: 1,  gap: 0, h2: 0, ev1: EV_S, off1: 9,  ev2: EV_N, off2: 0};
    vecs[8] = '{h1: 3,  gap: 1, h2: 1, ev1: EV_D, off1: 4,  ev2: EV_N, off2: 0};
    vecs[9] = '{h1: 15, gap: 0, h2: 0, ev1: EV_S, off1: 23, ev2: EV_N, off2: 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_events", int'(ev_vec), 0);
    chk("rst_busy", int'(busy_o), 0);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    chk("post_rst_busy", int'(busy_o), 0);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Long press with spurious pulses in HELD1 and LOCK: only one long_o.
    p_edge = edge_cnt + 1;
    push_ev(EV_L, p_edge + 16);
    step(1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (13) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    repeat (9) step(1'b0, 1'b1);
    chk("lock_busy_held", int'(busy_o), 1);
    idle_and_check("long_ignore", 40);

    // Asynchronous reset during WAIT2 with the button held through reset.
    step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    chk("wait2_busy", int'(busy_o), 1);
    btn_level = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy_o), 0);
    chk("async_rst_events", int'(ev_vec), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) step(1'b0, 1'b1);
    chk("held_after_rst_busy", int'(busy_o), 0);
    idle_and_check("after_rst", 20);
    run_vec(10, vecs[0]);

    // Random stress with realistic level/pulse pairs.
    sb_en = 1'b0;
    lvl = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 5) == 0) lvl = ~lvl;
      if (lvl && !prev) pulse_cnt++;
      step(lvl & ~prev, lvl);
      prev = lvl;
    end
    repeat (40) step(1'b0, 1'b0);
    checks++;
    if (ev_cnt > pulse_cnt) begin
      errors++;
      $display("FAIL stress_events: events %0d exceed pulses %0d", ev_cnt, pulse_cnt);
    end
    chk("stress_busy_idle", int'(busy_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/press_classifier.md
# press_classifier

Sits directly downstream of the button edge-detect stage and consumes its one-cycle press pulse plus the synchronized button level. Classifies each gesture as a single press, double press, or long press, and emits exactly one registered one-cycle event pulse per gesture. Game/menu control logic consumes these pulses in place of raw press pulses.

## Interface
- `WINDOW_CYCLES`, 25_000_000: max gap in cycles, measured from release, allowed before a second press (0.25 s at 100 MHz); ≥2.
- `LONG_CYCLES`, 100_000_000: hold length in cycles that qualifies as a long press (1 s at 100 MHz); ≥2.
- `CNT_W`, 27: counter width; must hold max(WINDOW_CYCLES, LONG_CYCLES)−1.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `press_pulse` in 1: one-cycle rising-edge pulse from the edge-detect stage.
- `btn_level` in 1: synchronized button level, taken from the same synchronizer chain that feeds the edge detector; high = pressed.
- `single_o` out 1: one-cycle pulse, single press recognized.
- `double_o` out 1: one-cycle pulse, double press recognized.
- `long_o` out 1: one-cycle pulse, long press recognized.
- `busy_o` out 1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, HELD1, WAIT2, LOCK. A single `CNT_W`-bit counter `cnt` is cleared on every state change.
- IDLE:
  - `press_pulse`=1 → HELD1.
  - Otherwise stay in IDLE.
- HELD1 (first press held):
  - `btn_level`=0 → WAIT2.
  - `cnt`==`LONG_CYCLES`−1 with `btn_level`=1 → assert `long_o`, go to LOCK.
  - Otherwise `cnt`++.
  - Release takes priority over the long-press terminal count in the same cycle.
- WAIT2 (released, awaiting second press):
  - `press_pulse`=1 → assert `double_o`, go to LOCK.
  - `cnt`==`WINDOW_CYCLES`−1 → assert `single_o`, go to IDLE.
  - Otherwise `cnt`++.
  - A press and the timeout in the same cycle resolve as a double press.
- LOCK: wait for `btn_level`=0, then go to IDLE. The second press of a double is never classified again, and a long press never also yields a single press.
- `press_pulse` is ignored in HELD1 and LOCK.
- At most one of `single_o`/`double_o`/`long_o` is high in any cycle.
- Counter never wraps: terminal compares stop it at the limit.
- Reset:
  - All outputs 0, state IDLE, `cnt`=0.
  - Reset mid-gesture discards the gesture with no event emitted.
  - After reset deassertion, a button still held does not produce an event until a new `press_pulse` arrives.

## Timing
- All outputs are registered and pulse high for exactly one cycle.
- Event pulses are asserted on the same clock edge as the state transition that produces them.
- Counter timing:
  - Entering WAIT2 at edge E gives `cnt`=0 during the following cycle.
  - `single_o` is high in the cycle after the edge at E+`WINDOW_CYCLES`.
- Long-press timing: `long_o` asserts on the edge that ends the `LONG_CYCLES`-th HELD1 cycle.
- `busy_o`:
  - Rises on the edge after `press_pulse`.
  - Falls on the edge that enters IDLE.
- Throughput: a new gesture can start in the cycle after returning to IDLE.

## Structure
- Shared package `press_pkg` holds:
  - State enum `press_state_t` (IDLE, HELD1, WAIT2, LOCK), 2-bit encoding.
  - Default constants `PRESS_WINDOW_DEF` and `PRESS_LONG_DEF`.
- Single flat module: FSM plus one shared counter. No sub-module is warranted.
- One instance per button, placed after that button's edge-detect instance.

## Test plan
All scenarios run with `WINDOW_CYCLES`=8, `LONG_CYCLES`=16.
- Single press: pulse, hold 3 cycles, release → one `single_o` 8 cycles after release is seen; no other outputs; `busy_o` low afterwards.
- Double press: pulse, hold 3, release, second pulse 4 cycles later, hold 5, release → `double_o` on the edge after the second pulse; no `single_o`; returns to IDLE after release.
- Long press: pulse, hold 30 cycles → `long_o` after 16 held cycles; nothing on release; a second pulse while held is ignored.
- Window boundary, two cases:
  - Second pulse in exactly the timeout cycle (`cnt`=7) → `double_o` only.
  - Second pulse one cycle later → `single_o`, and that pulse is treated as a new gesture only if it arrives in IDLE.
- Reset mid-gesture: assert `rst_n`=0 asynchronously during WAIT2 → outputs and `busy_o` drop immediately; no event is emitted after release of reset, even with the button held.
- Random stress: 10k random pulse/level sequences → at most one event per cycle, and events never exceed press pulses.
